// File: rtl/board_pkg.sv
// Shared board definitions for the frame receive path.
//   BOARD_BITS  : width of one board snapshot (81 cells x 2 bits)
//   SYNC_BYTE   : frame start marker on the UART link
//   cell_t      : 2-bit cell encoding
//   rx_state_t  : frame controller states
package board_pkg;
  localparam int         BOARD_BITS = 162;
  localparam logic [7:0] SYNC_BYTE  = 8'hA5;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_BLACK = 2'd1,
    CELL_WHITE = 2'd2
  } cell_t;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_PAYLOAD,
    ST_CHECKSUM
  } rx_state_t;
endpackage

// File: rtl/board_frame_rx_ctrl_if.sv
// Byte-in / board-out bundle of the frame receive controller.
//   byte_in, byte_valid_in            : raw byte stream from the UART receiver
//   board_out, board_valid_out,
//   board_ready_in                    : ready/valid board delivery
//   frame_err_out, timeout_err_out,
//   overrun_out, err_count_out        : error pulses and saturating count
// slave  : the controller side; master : the surrounding environment.
interface board_frame_rx_ctrl_if
  import board_pkg::*;
#(
  parameter int BOARD_W = BOARD_BITS
);
  logic [7:0]         byte_in;
  logic               byte_valid_in;
  logic [BOARD_W-1:0] board_out;
  logic               board_valid_out;
  logic               board_ready_in;
  logic               frame_err_out;
  logic               timeout_err_out;
  logic               overrun_out;
  logic [7:0]         err_count_out;

  modport slave (
    input  byte_in, byte_valid_in, board_ready_in,
    output board_out, board_valid_out, frame_err_out,
           timeout_err_out, overrun_out, err_count_out
  );

  modport master (
    output byte_in, byte_valid_in, board_ready_in,
    input  board_out, board_valid_out, frame_err_out,
           timeout_err_out, overrun_out, err_count_out
  );
endinterface

// File: rtl/board_frame_rx_ctrl_frame_gap_timer.sv
// Link watchdog: counts idle cycles between strobes while enabled.
//   clk_in, rst_in : clock, synchronous active-low reset
//   en             : watchdog armed; counter held at zero when low
//   load           : strobe seen this cycle; restarts the gap
//   expired        : gap has reached LIMIT and no strobe rescues it
module frame_gap_timer #(
  parameter int unsigned LIMIT = 100
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en,
  input  logic load,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // A strobe in the expiry cycle wins, so load masks the flag.
  assign expired = en && !load && (cnt == W'(LIMIT));

  always_ff @(posedge clk_in) begin
    if (!rst_in)            cnt <= '0;
    else if (!en || load)   cnt <= '0;
    else if (!expired)      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/board_frame_rx_ctrl.sv
// Frame controller behind the UART byte receiver. Hunts for SYNC_BYTE,
// assembles PAYLOAD_BYTES little-endian, checks an XOR checksum and zero
// pad bits, watches the inter-byte gap, and hands good boards out on a
// ready/valid slot.
//   clk_in, rst_in : clock, synchronous active-low reset
//   bus (slave)    : byte stream in, board + error pulses + err count out
module board_frame_rx_ctrl #(
  parameter logic [7:0]  SYNC_BYTE      = board_pkg::SYNC_BYTE,
  parameter int          PAYLOAD_BYTES  = 21,
  parameter int          BOARD_BITS     = board_pkg::BOARD_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  board_frame_rx_ctrl_if.slave  bus
);
  import board_pkg::*;

  localparam int ASM_BITS = 8 * PAYLOAD_BYTES;
  localparam int IDX_W    = $clog2(PAYLOAD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  rx_state_t state, state_nxt;

  logic [IDX_W-1:0]      idx;
  logic [ASM_BITS-1:0]   asm_q;
  logic [7:0]            xor_q;
  logic [BOARD_BITS-1:0] board_q;
  logic                  valid_q, ferr_q, terr_q, ovr_q;
  logic [7:0]            cnt_q;

  logic strobe, is_sync, expired, sum_ok, pad_ok, slot_free;
  logic good_evt, bad_evt, load_evt, ovr_evt, err_evt;

  assign strobe  = bus.byte_valid_in;
  assign is_sync = strobe && (bus.byte_in == SYNC_BYTE);

  frame_gap_timer #(.LIMIT(TIMEOUT_CYCLES)) u_gap (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .en      (state != ST_HUNT),
    .load    (strobe),
    .expired (expired)
  );

  // Bits above the board must be zero in a well-formed frame.
  assign sum_ok    = (bus.byte_in == xor_q);
  assign pad_ok    = (asm_q[ASM_BITS-1:BOARD_BITS] == '0);
  assign slot_free = !valid_q || bus.board_ready_in;
  assign load_evt  = good_evt && slot_free;
  assign ovr_evt   = good_evt && !slot_free;
  assign err_evt   = bad_evt || expired || ovr_evt;

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= ST_HUNT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    good_evt  = 1'b0;
    bad_evt   = 1'b0;
    case (state)
      ST_HUNT: begin
        if (is_sync) state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (strobe) begin
          if (idx == LAST_IDX) state_nxt = ST_CHECKSUM;
        end else if (expired) begin
          state_nxt = ST_HUNT;
        end
      end
      ST_CHECKSUM: begin
        if (strobe) begin
          state_nxt = ST_HUNT;
          good_evt  = sum_ok && pad_ok;
          bad_evt   = !(sum_ok && pad_ok);
        end else if (expired) begin
          state_nxt = ST_HUNT;
        end
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      idx     <= '0;
      asm_q   <= '0;
      xor_q   <= '0;
      board_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      terr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (state == ST_HUNT && is_sync) begin
        idx   <= '0;
        asm_q <= '0;
        xor_q <= '0;
      end else if (state == ST_PAYLOAD && strobe) begin
        asm_q[8*idx +: 8] <= bus.byte_in;
        xor_q             <= xor_q ^ bus.byte_in;
        idx               <= idx + 1'b1;
      end

      // A new load in the consume cycle keeps valid high.
      if (load_evt) begin
        board_q <= asm_q[BOARD_BITS-1:0];
        valid_q <= 1'b1;
      end else if (valid_q && bus.board_ready_in) begin
        valid_q <= 1'b0;
      end

      ferr_q <= bad_evt;
      terr_q <= expired;
      ovr_q  <= ovr_evt;
      if (err_evt && cnt_q != 8'hFF) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.board_out       = board_q;
  assign bus.board_valid_out = valid_q;
  assign bus.frame_err_out   = ferr_q;
  assign bus.timeout_err_out = terr_q;
  assign bus.overrun_out     = ovr_q;
  assign bus.err_count_out   = cnt_q;
endmodule

// File: tb/tb_board_frame_rx_ctrl.sv
module tb_board_frame_rx_ctrl;
  localparam int T  = 100;
  localparam int PB = 21;
  localparam int BB = 162;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  board_frame_rx_ctrl_if #(.BOARD_W(BB)) bus();

  board_frame_rx_ctrl #(
    .SYNC_BYTE(8'hA5), .PAYLOAD_BYTES(PB), .BOARD_BITS(BB), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [167:0] got, input logic [167:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (frame level, byte queue) -------------
  int            m_mode;   // 0 hunting, 1 collecting payload, 2 awaiting checksum
  logic [7:0]    m_q[$];
  int            m_gap;
  logic [BB-1:0] m_board;
  logic          m_valid, m_ferr, m_terr, m_ovr;
  int            m_cnt;
  bit            rand_rdy = 0;

  function automatic logic [167:0] pack_bytes();
    logic [167:0] v = '0;
    for (int k = 0; k < m_q.size(); k++) v = v | (168'(m_q[k]) << (8 * k));
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_q.delete(); m_gap = 0; m_board = '0; m_valid = 0;
    m_ferr = 0; m_terr = 0; m_ovr = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic v, r, acc;
    logic [7:0] b, x;
    logic [167:0] full;
    v = bus.byte_valid_in; b = bus.byte_in; r = bus.board_ready_in;
    if (!rst_in) begin
      model_reset();
      return;
    end
    m_ferr = 0; m_terr = 0; m_ovr = 0; acc = 0; full = '0;
    if (m_mode == 0) begin
      if (v && b == 8'hA5) begin m_mode = 1; m_q.delete(); m_gap = 0; end
    end else if (v) begin
      m_gap = 0;
      if (m_mode == 1) begin
        m_q.push_back(b);
        if (m_q.size() == PB) m_mode = 2;
      end else begin
        x = 8'h00;
        foreach (m_q[k]) x = x ^ m_q[k];
        full = pack_bytes();
        if (b == x && full[167:BB] == '0) begin
          if (!m_valid || r) acc = 1; else m_ovr = 1;
        end else m_ferr = 1;
        m_mode = 0;
      end
    end else if (m_gap == T) begin
      m_terr = 1; m_mode = 0;
    end else m_gap++;

    if (acc) begin m_board = full[BB-1:0]; m_valid = 1; end
    else if (m_valid && r) m_valid = 0;
    if ((m_ferr || m_terr || m_ovr) && m_cnt < 255) m_cnt++;
  endtask

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    chk("valid", 168'(bus.board_valid_out), 168'(m_valid));
    chk("board", 168'(bus.board_out),       168'(m_board));
    chk("ferr",  168'(bus.frame_err_out),   168'(m_ferr));
    chk("terr",  168'(bus.timeout_err_out), 168'(m_terr));
    chk("ovr",   168'(bus.overrun_out),     168'(m_ovr));
    chk("cnt",   168'(bus.err_count_out),   168'(m_cnt));
    if (rand_rdy) bus.board_ready_in = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] b);
    bus.byte_in = b;
    bus.byte_valid_in = 1'b1;
    step();
    bus.byte_valid_in = 1'b0;
    bus.byte_in = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  logic [7:0] frm [PB];

  function automatic logic [7:0] frm_xor();
    logic [7:0] x = 8'h00;
    for (int k = 0; k < PB; k++) x = x ^ frm[k];
    return x;
  endfunction

  task automatic send_frame(input logic [7:0] cs, input int gmax);
    send(8'hA5);
    for (int k = 0; k < PB; k++) begin
      send(frm[k]);
      if (gmax > 0) idle($urandom_range(0, gmax));
    end
    send(cs);
  endtask

  task automatic fill_good(input logic [7:0] fillv, input logic [7:0] lastv);
    for (int k = 0; k < PB - 1; k++) frm[k] = fillv;
    frm[PB-1] = lastv;
  endtask

  // ---------------- test sequence ------------------------------------------
  initial begin
    logic [BB-1:0] held;
    bus.byte_in = 8'h00; bus.byte_valid_in = 1'b0; bus.board_ready_in = 1'b0;
    model_reset();
    rst_in = 1'b0;
    idle(2);
    chk("rst_valid", 168'(bus.board_valid_out), 168'(0));
    chk("rst_board", 168'(bus.board_out), 168'(0));
    rst_in = 1'b1;
    idle(2);

    // nonzero pad bits -> frame error
    for (int k = 0; k < PB; k++) frm[k] = 8'(k + 1);
    send_frame(frm_xor(), 0);
    chk("pad_ferr", 168'(bus.frame_err_out), 168'(1));
    chk("pad_cnt", 168'(bus.err_count_out), 168'(1));
    idle(1);
    chk("pad_valid", 168'(bus.board_valid_out), 168'(0));

    // good frame
    fill_good(8'h11, 8'h03);
    send_frame(8'h03, 0);
    chk("good_valid", 168'(bus.board_valid_out), 168'(1));
    chk("good_lo", 168'(bus.board_out[7:0]), 168'(8'h11));
    chk("good_hi", 168'(bus.board_out[161:160]), 168'(2'b11));
    held = bus.board_out;

    // repeat with ready low -> overrun, board held
    send_frame(8'h03, 2);
    chk("ovr_pulse", 168'(bus.overrun_out), 168'(1));
    chk("ovr_board", 168'(bus.board_out), 168'(held));
    bus.board_ready_in = 1'b1;
    step();
    chk("drain_valid", 168'(bus.board_valid_out), 168'(0));

    // mid-frame timeout, then a good frame
    send(8'hA5);
    for (int k = 0; k < 10; k++) send(8'(k));
    idle(T);
    chk("to_quiet", 168'(bus.timeout_err_out), 168'(0));
    idle(1);
    chk("to_pulse", 168'(bus.timeout_err_out), 168'(1));
    idle(3);
    bus.board_ready_in = 1'b0;
    fill_good(8'h5A, 8'h01);
    send_frame(8'h01, 1);
    chk("to_after", 168'(bus.board_valid_out), 168'(1));
    bus.board_ready_in = 1'b1;
    idle(1);

    // sync values inside payload are data
    fill_good(8'hA5, 8'h02);
    send_frame(8'h02, 0);
    chk("a5_valid", 168'(bus.board_valid_out), 168'(1));
    chk("a5_lo", 168'(bus.board_out[15:0]), 168'(16'hA5A5));
    idle(2);

    // reset in the middle of a payload
    send(8'hA5);
    for (int k = 0; k < 5; k++) send(8'hFF);
    rst_in = 1'b0;
    step();
    chk("mrst_cnt", 168'(bus.err_count_out), 168'(0));
    chk("mrst_valid", 168'(bus.board_valid_out), 168'(0));
    rst_in = 1'b1;
    fill_good(8'h3C, 8'h00);
    send_frame(8'h00, 0);
    chk("mrst_good", 168'(bus.board_valid_out), 168'(1));

    // randomized frames, gaps, checksums and ready
    rand_rdy = 1;
    for (int f = 0; f < 200; f++) begin
      int kind = $urandom_range(0, 9);
      logic [7:0] cs;
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 255)));
      for (int k = 0; k < PB; k++) frm[k] = 8'($urandom);
      if (kind != 0) frm[PB-1] = frm[PB-1] & 8'h03;
      cs = frm_xor();
      if (kind == 1) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      if (kind == 2) begin
        send(8'hA5);
        for (int k = 0; k < $urandom_range(0, PB); k++) send(frm[k]);
        idle(T + $urandom_range(0, 3));
      end else begin
        send_frame(cs, (kind == 3) ? 3 : 0);
      end
    end
    rand_rdy = 0;

    // saturate the error counter
    bus.board_ready_in = 1'b1;
    fill_good(8'h00, 8'h00);
    for (int i = 0; i < 300; i++) send_frame(8'h77, 0);
    chk("sat_cnt", 168'(bus.err_count_out), 168'(255));
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/board_frame_rx_ctrl.md
# board_frame_rx_ctrl

Frame controller that sits directly behind the UART byte receiver and turns its raw byte stream into validated 162-bit board snapshots (81 cells × 2 bits). It hunts for a sync byte, collects a fixed-length payload, checks an XOR checksum and enforces an inter-byte timeout. It presents each good frame on a ready/valid port to the game logic and drops bad frames with a one-cycle error pulse.

## Interface

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- PAYLOAD_BYTES, 21, payload length in bytes; 21 × 8 = 168 ≥ BOARD_BITS
- BOARD_BITS, 162, width of the delivered board
- TIMEOUT_CYCLES, 2_000_000, maximum clk_in cycles between consecutive bytes inside a frame (20 ms at 100 MHz)

Ports:
- clk_in  input  1  system clock; single clock domain
- rst_in  input  1  reset; synchronous, active-low
- byte_in  input  8  received byte, qualified by byte_valid_in
- byte_valid_in  input  1  one-cycle strobe per received byte
- board_out  output  162  last accepted board; held stable while board_valid_out is high
- board_valid_out  output  1  board_out holds an undelivered frame
- board_ready_in  input  1  consumer accepts board_out when high with board_valid_out
- frame_err_out  output  1  one-cycle pulse: checksum mismatch or nonzero pad bits
- timeout_err_out  output  1  one-cycle pulse: inter-byte gap exceeded mid-frame
- overrun_out  output  1  one-cycle pulse: good frame dropped because output slot was full
- err_count_out  output  8  saturating count of all three error events

## Operation

- States: HUNT, PAYLOAD, CHECKSUM.
- HUNT: ignore every byte except SYNC_BYTE; on it, clear byte index, shift register and running XOR, then go to PAYLOAD. No timeout in HUNT.
- PAYLOAD: each strobed byte is stored little-endian: payload byte k occupies assembly bits [8k+7:8k]; running XOR ^= byte. SYNC_BYTE values here are data, not resync. After byte PAYLOAD_BYTES−1, go to CHECKSUM.
- CHECKSUM: the next strobed byte is compared with the running XOR. Good frame requires match AND assembly bits [167:162] all zero. Go to HUNT in every case.
- Good frame: if the slot is free (board_valid_out low, or board_ready_in high this cycle), load board_out and set board_valid_out; otherwise drop the frame, pulse overrun_out, keep old board_out.
- Bad frame: pulse frame_err_out; board_out/board_valid_out untouched.
- Timeout: in PAYLOAD or CHECKSUM, gap counter resets on each strobe and increments otherwise; reaching TIMEOUT_CYCLES pulses timeout_err_out and returns to HUNT.
- board_valid_out clears on board_valid_out && board_ready_in unless a new frame loads in the same cycle.
- err_count_out increments by one per error pulse (at most one pulse per cycle), saturates at 255.

## Timing

- Reset (rst_in low at a clk_in edge): state HUNT, board_out = 0, board_valid_out = 0, all pulses 0, err_count_out = 0, counters 0. Reset mid-frame discards the partial frame.
- board_valid_out and board_out update on the edge after the clk_in edge that samples the checksum strobe (1-cycle latency).
- Error pulses assert for exactly one cycle, on the edge after the triggering strobe or the timeout count.
- Timeout fires when the gap counter equals TIMEOUT_CYCLES; a strobe in that same cycle wins (counts as a byte, no timeout).
- Gap counter width: $clog2(TIMEOUT_CYCLES+1); byte index width: $clog2(PAYLOAD_BYTES).
- Strobes may arrive back-to-back every cycle; no byte is lost.

## Structure

- Shared package board_pkg: BOARD_BITS, cell encoding typedef (EMPTY/BLACK/WHITE), SYNC_BYTE, state enum for this block.
- One natural sub-module: frame_gap_timer (load-on-strobe counter with enable and expiry flag), reusable for other link watchdogs.

## Test plan

- Sync A5, 21 bytes 0x01..0x15 (last byte 0x15 has bits[7:2]=0x05 → pad nonzero) → frame_err_out pulse, board_valid_out stays 0, err_count_out = 1.
- Sync A5, 20 bytes 0x11, byte 0x03, checksum 0x03 → board_valid_out one cycle after checksum; board_out[7:0] = 0x11, board_out[161:160] = 2'b11.
- Same good frame twice with board_ready_in held low → second frame pulses overrun_out, board_out unchanged; raise ready → valid drops next cycle.
- Sync, 10 payload bytes, then silence TIMEOUT_CYCLES (parameter set to 100 in bench) → timeout_err_out at cycle 100 of gap, state HUNT; following good frame is accepted.
- Payload containing 0xA5 bytes with correct checksum → accepted (no resync), board_out matches.
- rst_in low for one cycle mid-PAYLOAD → all outputs zero; subsequent complete frame accepted normally; 300 forced errors → err_count_out = 255.
